// File: rtl/uv_rst_ctrl.sv
// uv_rst_ctrl: merges watchdog, external-pin and software reset requests into
// one stretched system reset and keeps sticky reset-cause flags readable over APB.
module uv_rst_ctrl #(
    parameter int unsigned ALEN        = 12,
    parameter int unsigned DLEN        = 32,
    parameter int unsigned MLEN        = DLEN / 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_W      = 8,
    parameter int unsigned HOLD_DEF    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_rst_n,
    input  logic              wdt_rst_n,
    input  logic              rst_psel,
    input  logic              rst_penable,
    input  logic [2:0]        rst_pprot,
    input  logic [ALEN-1:0]   rst_paddr,
    input  logic [MLEN-1:0]   rst_pstrb,
    input  logic              rst_pwrite,
    input  logic [DLEN-1:0]   rst_pwdata,
    output logic [DLEN-1:0]   rst_prdata,
    output logic              rst_pready,
    output logic              rst_pslverr,
    output logic              sys_rst_n,
    output logic [1:0]        rst_state
);

    localparam int unsigned IDX_W = ALEN - 2;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   ext_s;
    logic                   wdt_q;
    logic                   sw_req;
    logic                   req;

    logic [1:0]             state;
    logic [1:0]             next_state;
    logic [HOLD_W-1:0]      cnt;
    logic [HOLD_W-1:0]      cnt_n;
    logic [HOLD_W-1:0]      cfg_hold;
    logic [HOLD_W-1:0]      cfg_n;
    logic [3:0]             cause;
    logic [3:0]             cause_n;
    logic [3:0]             cause_set;
    logic [3:0]             cause_clr;

    logic                   access;
    logic                   wr_en;
    logic [IDX_W-1:0]       idx;
    logic                   sw_fire;
    logic                   unused_apb;

    assign ext_s      = ext_sync[SYNC_STAGES-1];
    assign req        = ~ext_s | ~wdt_q | sw_req;
    assign access     = rst_psel & rst_penable;
    assign wr_en      = access & rst_pwrite;
    assign idx        = rst_paddr[ALEN-1:2];
    assign rst_pready = 1'b1;
    assign rst_state  = state;
    assign unused_apb = ^{rst_pprot, rst_paddr[1:0], rst_pwdata, rst_pstrb};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_HOLD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and hold-counter update
    always_comb begin
        next_state = state;
        cnt_n      = cnt;
        case (state)
            ST_RUN: begin
                if (req) begin
                    next_state = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!req) begin
                    next_state = ST_HOLD;
                    cnt_n      = cfg_hold;
                end
            end
            ST_HOLD: begin
                if (req) begin
                    next_state = ST_ASSERT;
                end else if (cnt == '0) begin
                    next_state = ST_RUN;
                end else begin
                    cnt_n = cnt - HOLD_W'(1);
                end
            end
            default: begin
                next_state = ST_HOLD;
            end
        endcase
    end

    // Cause set/clear; a source active in the same cycle as a W1C keeps its bit
    always_comb begin
        cause_set = req ? {sw_req, ~wdt_q, ~ext_s, 1'b0} : 4'b0000;
        cause_clr = 4'b0000;
        if (wr_en && idx == IDX_W'(0) && rst_pstrb[0]) begin
            cause_clr = rst_pwdata[3:0];
        end
        cause_n = (cause & ~cause_clr) | cause_set;
    end

    // CFG write with byte strobes, and software reset trigger decode
    always_comb begin
        cfg_n = cfg_hold;
        if (wr_en && idx == IDX_W'(1)) begin
            for (int b = 0; b < int'(HOLD_W); b++) begin
                if (rst_pstrb[b / 8]) begin
                    cfg_n[b] = rst_pwdata[b];
                end
            end
        end
        sw_fire = wr_en && (idx == IDX_W'(2)) && rst_pstrb[0] && (rst_pwdata[7:0] == 8'h5A);
    end

    // Source capture, counter, registered reset output and register file
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_sync  <= '1;
            wdt_q     <= 1'b1;
            sw_req    <= 1'b0;
            cnt       <= HOLD_W'(HOLD_DEF);
            sys_rst_n <= 1'b0;
            cause     <= 4'b0001;
            cfg_hold  <= HOLD_W'(HOLD_DEF);
        end else begin
            ext_sync  <= {ext_sync[SYNC_STAGES-2:0], ext_rst_n};
            wdt_q     <= wdt_rst_n;
            sw_req    <= sw_fire;
            cnt       <= cnt_n;
            sys_rst_n <= (next_state == ST_RUN);
            cause     <= cause_n;
            cfg_hold  <= cfg_n;
        end
    end

    // APB read mux and error decode, live only during the access phase
    always_comb begin
        rst_prdata  = '0;
        rst_pslverr = 1'b0;
        if (access && rst_n) begin
            case (idx)
                IDX_W'(0): rst_prdata = DLEN'(cause);
                IDX_W'(1): rst_prdata = DLEN'(cfg_hold);
                IDX_W'(2): rst_prdata = '0;
                IDX_W'(3): rst_prdata = DLEN'(state);
                default:   rst_pslverr = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uv_rst_ctrl.sv
// tb_uv_rst_ctrl: scoreboard bench; a cycle-indexed reference model predicts
// sys_rst_n/rst_state every cycle and the APB response of every access.
`timescale 1ns/1ps
module tb_uv_rst_ctrl;

    localparam int unsigned S    = 2;
    localparam int unsigned HDEF = 16;
    localparam int          NCYC = 16384;

    logic        clk;
    logic        rst_n, ext_rst_n, wdt_rst_n;
    logic        psel, penable, pwrite;
    logic [2:0]  pprot;
    logic [11:0] paddr;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, sys_rst_n;
    logic [1:0]  rst_state;

    uv_rst_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ext_rst_n(ext_rst_n), .wdt_rst_n(wdt_rst_n),
        .rst_psel(psel), .rst_penable(penable), .rst_pprot(pprot), .rst_paddr(paddr),
        .rst_pstrb(pstrb), .rst_pwrite(pwrite), .rst_pwdata(pwdata),
        .rst_prdata(prdata), .rst_pready(pready), .rst_pslverr(pslverr),
        .sys_rst_n(sys_rst_n), .rst_state(rst_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic sys; logic [1:0] st; } sys_exp_t;
    typedef struct { logic [31:0] data; logic err; bit chk_data; } apb_exp_t;

    sys_exp_t exp_q[$];
    apb_exp_t apb_q[$];
    int errors = 0;
    int checks = 0;

    // Input history per cycle, and model state
    bit         ext_h [NCYC];
    bit         wdt_h [NCYC];
    bit         swf_h [NCYC];
    logic [7:0] cfg_h [NCYC];
    int         cyc = 0;
    int         rst_cyc = 0;
    int         last_a = 0;
    bit         por_h = 1'b1;
    logic [3:0] m_cause = 4'h1;
    logic [7:0] m_cfg = 8'(HDEF);
    int         m_st = 2;
    bit         p_rst, p_wr;
    int         p_idx;
    logic [3:0] p_strb;
    logic [31:0] p_data;

    // Active sources as seen inside the block during cycle k: {SW, WDT, EXT, 0}
    function automatic logic [3:0] src_act(int k);
        logic w, e, s;
        w = (k - 1 >= rst_cyc) ? wdt_h[k-1] : 1'b1;
        e = (k - int'(S) >= rst_cyc) ? ext_h[k-int'(S)] : 1'b1;
        s = (k - 1 >= rst_cyc) ? swf_h[k-1] : 1'b0;
        return {s, ~w, ~e, 1'b0};
    endfunction

    // Advance the model to cycle cyc, given what happened during cycle cyc-1
    task automatic model_step();
        logic [3:0] act, clr;
        int h;
        if (!p_rst) begin
            rst_cyc = cyc;
            m_cause = 4'h1;
            m_cfg   = 8'(HDEF);
            last_a  = cyc - 1;
            por_h   = 1'b1;
            m_st    = 2;
        end else begin
            act = src_act(cyc - 1);
            clr = (p_wr && p_idx == 0 && p_strb[0]) ? p_data[3:0] : 4'h0;
            m_cause = (m_cause & ~clr) | act;
            if (p_wr && p_idx == 1 && p_strb[0]) m_cfg = p_data[7:0];
            h = por_h ? int'(HDEF) : int'(cfg_h[last_a]);
            if (act != 4'h0) begin
                m_st   = 1;
                last_a = cyc;
                por_h  = 1'b0;
            end else if (cyc <= last_a + 1 + h) begin
                m_st = 2;
            end else begin
                m_st = 0;
            end
        end
        cfg_h[cyc] = m_cfg;
        exp_q.push_back('{(m_st == 0), 2'(m_st)});
    endtask

    // Record the inputs of the ending cycle, then move to the next one
    task automatic tick();
        p_rst  = rst_n;
        p_wr   = psel & penable & pwrite;
        p_idx  = int'(paddr[11:2]);
        p_strb = pstrb;
        p_data = pwdata;
        ext_h[cyc] = ext_rst_n;
        wdt_h[cyc] = wdt_rst_n;
        swf_h[cyc] = rst_n && p_wr && p_idx == 2 && pstrb[0] && (pwdata[7:0] == 8'h5A);
        if (cyc >= NCYC - 2) begin
            $display("FAIL cycle_budget cyc=%0d exceeded limit %0d", cyc, NCYC);
            $fatal(1);
        end
        @(posedge clk);
        #1;
        cyc++;
        model_step();
    endtask

    task automatic apb_write(int idx, logic [31:0] d, logic [3:0] s);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'(idx * 4 + int'($urandom_range(0, 3)));
        pwdata = d; pstrb = s; pprot = 3'($urandom);
        tick();
        penable = 1'b1;
        apb_q.push_back('{32'h0, (idx > 3), 1'b0});
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(int idx);
        logic [31:0] e;
        logic        err;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        paddr = 12'(idx * 4 + int'($urandom_range(0, 3)));
        pwdata = $urandom; pstrb = 4'($urandom); pprot = 3'($urandom);
        tick();
        penable = 1'b1;
        err = 1'b0;
        case (idx)
            0:       e = 32'(m_cause);
            1:       e = 32'(m_cfg);
            2:       e = 32'h0;
            3:       e = 32'(m_st);
            default: begin e = 32'h0; err = 1'b1; end
        endcase
        apb_q.push_back('{e, err, 1'b1});
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    // Monitor: compares every cycle's reset output and every APB access phase
    sys_exp_t me;
    apb_exp_t ma;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            checks++;
            if (sys_rst_n !== me.sys || rst_state !== me.st) begin
                errors++;
                $display("FAIL sys_state cyc=%0d got sys_rst_n=%b rst_state=%0d exp sys_rst_n=%b rst_state=%0d",
                         cyc, sys_rst_n, rst_state, me.sys, me.st);
            end
        end
        if (psel && penable) begin
            checks++;
            if (apb_q.size() == 0) begin
                errors++;
                $display("FAIL apb_unexpected cyc=%0d access with no expectation queued", cyc);
            end else begin
                ma = apb_q.pop_front();
                if (pslverr !== ma.err || pready !== 1'b1 || (ma.chk_data && prdata !== ma.data)) begin
                    errors++;
                    $display("FAIL apb_resp cyc=%0d addr=%h got prdata=%h pslverr=%b pready=%b exp prdata=%h pslverr=%b",
                             cyc, paddr, prdata, pslverr, pready, ma.data, ma.err);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        rst_n = 1'b0; ext_rst_n = 1'b1; wdt_rst_n = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pprot = 3'h0; paddr = 12'h0; pstrb = 4'h0; pwdata = 32'h0;

        // Power-on reset for 3 cycles, then let the hold window expire
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (22) tick();
        apb_read(0);
        apb_read(1);
        apb_read(3);

        // Watchdog pulse of 5 cycles, then W1C of the POR bit
        wdt_rst_n = 1'b0;
        repeat (5) tick();
        wdt_rst_n = 1'b1;
        repeat (28) tick();
        apb_read(0);
        apb_write(0, 32'h1, 4'h1);
        apb_read(0);

        // Software reset with a short hold; a wrong key does nothing
        apb_write(1, 32'h3, 4'h1);
        apb_write(0, 32'hF, 4'h1);
        apb_write(2, 32'h5A, 4'h1);
        repeat (10) tick();
        apb_read(0);
        apb_read(2);
        apb_write(2, 32'h5B, 4'h1);
        repeat (10) tick();
        apb_write(2, 32'h5A, 4'h2);
        repeat (6) tick();

        // External glitch while a longer hold is counting down
        apb_write(1, 32'hA, 4'h1);
        apb_write(2, 32'h5A, 4'hF);
        repeat (7) tick();
        ext_rst_n = 1'b0;
        tick();
        ext_rst_n = 1'b1;
        repeat (25) tick();
        apb_read(0);

        // Overlapping watchdog and external requests with default hold
        apb_write(1, 32'h10, 4'h1);
        for (int i = 0; i < 20; i++) begin
            wdt_rst_n = (i >= 10);
            ext_rst_n = (i < 4);
            tick();
        end
        wdt_rst_n = 1'b1; ext_rst_n = 1'b1;
        repeat (25) tick();
        apb_read(0);

        // APB error and read-only handling, and set-beats-clear
        apb_read(5);
        apb_write(3, 32'hFFFF_FFFF, 4'hF);
        apb_read(3);
        apb_write(6, 32'h0000_00FF, 4'hF);
        apb_read(1);
        wdt_rst_n = 1'b0;
        repeat (3) tick();
        apb_write(0, 32'h4, 4'h1);
        apb_read(0);
        wdt_rst_n = 1'b1;
        repeat (20) tick();

        // Reset asserted in the middle of a hold window
        apb_write(2, 32'h5A, 4'h1);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        apb_read(0);

        // Randomized mix of sources and register traffic
        for (int n = 0; n < 160; n++) begin
            case ($urandom_range(0, 8))
                0: repeat ($urandom_range(1, 20)) tick();
                1: begin
                    wdt_rst_n = 1'b0;
                    repeat ($urandom_range(1, 8)) tick();
                    wdt_rst_n = 1'b1;
                end
                2: begin
                    ext_rst_n = 1'b0;
                    repeat ($urandom_range(1, 8)) tick();
                    ext_rst_n = 1'b1;
                end
                3: begin
                    d = $urandom;
                    if ($urandom_range(0, 1) == 1) d[7:0] = 8'h5A;
                    apb_write(2, d, 4'($urandom));
                end
                4: apb_write(1, 32'($urandom_range(0, 20)), 4'($urandom));
                5: apb_write(0, $urandom, 4'($urandom));
                6: apb_read(int'($urandom_range(0, 7)));
                7: apb_write(int'($urandom_range(3, 7)), $urandom, 4'hF);
                default: begin
                    rst_n = 1'b0;
                    repeat ($urandom_range(1, 3)) tick();
                    rst_n = 1'b1;
                end
            endcase
        end
        wdt_rst_n = 1'b1; ext_rst_n = 1'b1;
        repeat (30) tick();
        apb_read(0);
        apb_read(3);
        tick();
        @(negedge clk);
        #1;

        checks++;
        if (exp_q.size() != 0 || apb_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got sys_left=%0d apb_left=%0d exp 0 and 0", exp_q.size(), apb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
